// File: rtl/msb_serializer_pkg.sv
// Shared types and constants for the MSB-first word serializer.
package msb_serializer_pkg;

   localparam int unsigned SER_W_DEFAULT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/msb_serializer.sv
// MSB-first serializer feeding a bit-serial downstream checker via ser_din/ser_rstn.
// Define SER_LEN_EN to add the in_len port (per-word length, 0 or >W means W).
module msb_serializer
   import msb_serializer_pkg::*;
#(
   parameter int unsigned W = SER_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_data,
`ifdef SER_LEN_EN
   input  logic [$clog2(W+1)-1:0] in_len,
`endif
   output logic                   ser_din,
   output logic                   ser_rstn,
   output logic                   word_done
);

   localparam int unsigned CW = $clog2(W+1);

   state_t        state_q, state_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [CW-1:0] len_eff_c;

`ifdef SER_LEN_EN
   always_comb begin
      len_eff_c = in_len;
      if (in_len == '0 || 32'(in_len) > W) len_eff_c = CW'(W);
   end
`else
   assign len_eff_c = CW'(W);
`endif

   // Word is left-aligned on load so bit L-1 leaves first and zeros fill behind,
   // leaving the register clear (ser_din=0) once the last bit has gone out.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
               sh_d    = in_data << (CW'(W) - len_eff_c);
               cnt_d   = len_eff_c;
            end
         end
         SHIFT: begin
            sh_d  = {sh_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Downstream is held in clear whenever no data bit is on ser_din.
   assign in_ready  = (state_q == IDLE);
   assign ser_rstn  = (state_q == SHIFT);
   assign ser_din   = sh_q[W-1];
   assign word_done = done_q;

endmodule

// File: tb/tb_msb_serializer.sv
// Self-checking bench for msb_serializer (W=8); honours SER_LEN_EN when defined.
module tb_msb_serializer;

   logic       clk;
   logic       resetn;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
`ifdef SER_LEN_EN
   logic [3:0] in_len;
`endif
   logic       ser_din;
   logic       ser_rstn;
   logic       word_done;

   int errors = 0;
   int checks = 0;

   // Behavioural divisible-by-3 checker: running remainder of the bits shifted in.
   logic [1:0] rem;

   msb_serializer #(.W(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef SER_LEN_EN
      .in_len    (in_len),
`endif
      .ser_din   (ser_din),
      .ser_rstn  (ser_rstn),
      .word_done (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ser_rstn) rem <= 2'd0;
      else           rem <= 2'((int'(rem) * 2 + int'(ser_din)) % 3);
   end

   // Offers one word at a negedge, checks every bit cycle and the done cycle.
   // Returns at the negedge of the word_done cycle.
   task automatic run_word(input logic [7:0] d, input int len, input bit hold);
      int         eff;
      logic [7:0] low;
      eff = 8;
`ifdef SER_LEN_EN
      if (len >= 1 && len <= 8) eff = len;
      in_len = 4'(len);
`endif
      low = (eff == 8) ? d : (d & 8'((1 << eff) - 1));
      in_valid = 1'b1;
      in_data  = d;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready word=%h got=%b want=1", d, in_ready);
      end
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      in_data = 8'($urandom);
`ifdef SER_LEN_EN
      in_len = 4'($urandom);
`endif
      for (int i = 0; i < eff; i++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, ser_rstn, ser_din, word_done} !== {1'b0, 1'b1, d[eff-1-i], 1'b0}) begin
            errors++;
            $display("FAIL bit word=%h idx=%0d got rdy/rstn/din/done=%b%b%b%b want=01%b0",
                     d, i, in_ready, ser_rstn, ser_din, word_done, d[eff-1-i]);
         end
      end
      @(negedge clk);
      checks++;
      if ({in_ready, ser_rstn, ser_din, word_done} !== 4'b1001) begin
         errors++;
         $display("FAIL done word=%h got rdy/rstn/din/done=%b%b%b%b want=1001",
                  d, in_ready, ser_rstn, ser_din, word_done);
      end
      checks++;
      if (rem !== 2'(low % 8'd3)) begin
         errors++;
         $display("FAIL mod3 word=%h len=%0d got=%0d want=%0d", d, eff, rem, low % 8'd3);
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({in_ready, ser_rstn, ser_din, word_done} !== 4'b1000) begin
            errors++;
            $display("FAIL in_reset got rdy/rstn/din/done=%b%b%b%b want=1000",
                     in_ready, ser_rstn, ser_din, word_done);
         end
      end
      in_valid = 1'b0;
      resetn   = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, ser_rstn, ser_din, word_done} !== 4'b1000) begin
         errors++;
         $display("FAIL after_reset got rdy/rstn/din/done=%b%b%b%b want=1000",
                  in_ready, ser_rstn, ser_din, word_done);
      end
   endtask

   task automatic test_idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_data = 8'($urandom);
         @(negedge clk);
         checks++;
         if ({in_ready, ser_rstn, ser_din, word_done} !== 4'b1000) begin
            errors++;
            $display("FAIL idle cyc=%0d got rdy/rstn/din/done=%b%b%b%b want=1000",
                     i, in_ready, ser_rstn, ser_din, word_done);
         end
      end
   endtask

   task automatic test_known_words();
      run_word(8'h06, 8, 1'b0);
      test_idle(1);
      run_word(8'h07, 8, 1'b0);
      test_idle(2);
   endtask

   task automatic test_back_to_back();
      run_word(8'h03, 8, 1'b1);
      run_word(8'hFF, 8, 1'b0);
      test_idle(1);
   endtask

   task automatic test_reset_mid_word();
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, ser_rstn, ser_din, word_done} !== {1'b0, 1'b1, ~i[0], 1'b0}) begin
            errors++;
            $display("FAIL abort_bit idx=%0d got rdy/rstn/din/done=%b%b%b%b want=01%b0",
                     i, in_ready, ser_rstn, ser_din, word_done, ~i[0]);
         end
      end
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, ser_rstn, ser_din, word_done} !== 4'b1000) begin
         errors++;
         $display("FAIL abort_reset got rdy/rstn/din/done=%b%b%b%b want=1000",
                  in_ready, ser_rstn, ser_din, word_done);
      end
      resetn = 1'b1;
      test_idle(6);
      run_word(8'h09, 8, 1'b0);
      test_idle(1);
   endtask

`ifdef SER_LEN_EN
   task automatic test_length();
      run_word(8'h05, 3, 1'b0);
      test_idle(1);
      run_word(8'hB4, 0, 1'b0);
      run_word(8'hC5, 12, 1'b0);
      run_word(8'h80, 1, 1'b1);
      run_word(8'h3E, 7, 1'b0);
      test_idle(1);
   endtask
`endif

   task automatic test_random(input int n);
      int gap;
      for (int k = 0; k < n; k++) begin
         gap = int'($urandom_range(0, 3));
         run_word(8'($urandom), int'($urandom_range(0, 9)), gap == 0);
         if (gap > 0) test_idle(gap);
      end
      test_idle(1);
   endtask

   initial begin
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
`ifdef SER_LEN_EN
      in_len   = 4'd0;
`endif
      test_reset();
      test_idle(20);
      test_known_words();
      test_back_to_back();
      test_reset_mid_word();
`ifdef SER_LEN_EN
      test_length();
`endif
      test_random(40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/msb_serializer.md
MSB_SERIALIZER -- requirements
Module: msb_serializer

Interface
REQ-001 Parameter W, 8, input word width in bits (W >= 2) SHALL be provided.
REQ-002 Port clk  input  1  clock; all logic SHALL be rising-edge.
REQ-003 Port resetn  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  parallel word offered.
REQ-005 Port in_ready  output  1  serializer can accept a word.
REQ-006 Port in_data  input  W  word, bit W-1 sent first.
REQ-007 Port in_len  input  $clog2(W+1)  bits to send, present only with SER_LEN_EN.
REQ-008 Port ser_din  output  1  serial bit to downstream divisibility checker.
REQ-009 Port ser_rstn  output  1  synchronous active-low clear to downstream checker.
REQ-010 Port word_done  output  1  one-cycle pulse; downstream result valid this cycle.

Function
REQ-011 FSM states SHALL be IDLE and SHIFT only.
REQ-012 IDLE: in_ready=1, ser_rstn=0, ser_din=0.
REQ-013 Accept SHALL occur on a clock edge with in_valid=1 and in_ready=1; word and length are latched into a shift register and bit counter, and the FSM goes to SHIFT.
REQ-014 SHIFT: in_ready=0, ser_rstn=1, ser_din=MSB of the shift register; each cycle the register shifts left by 1 and the counter decrements.
REQ-015 With accept at edge N, ser_din SHALL carry word bits L-1..0 in cycles N+1..N+L, with no gaps; L is the effective length.
REQ-016 At the edge ending the cycle that carries bit 0, the FSM SHALL return to IDLE.
REQ-017 word_done SHALL be registered and high exactly in cycle N+L+1, the first IDLE cycle.
REQ-018 In that cycle the downstream register state reflects all L bits. ser_rstn=0 then clears the downstream register at the following edge.
REQ-019 A new word MAY be accepted in the word_done cycle, giving a back-to-back period of L+1 cycles per word.
REQ-020 in_data and in_len SHALL be ignored outside the accept edge; in_valid without in_ready SHALL have no effect.
REQ-021 ser_rstn SHALL be low in every cycle in which no word bit is presented, so the downstream checker never shifts a non-data bit.

Reset
REQ-022 resetn=0 at an edge SHALL force IDLE, clear the shift register, clear the counter and clear word_done.
REQ-023 Outputs during and after reset SHALL be: in_ready=1, ser_rstn=0, ser_din=0, word_done=0.
REQ-024 Reset during SHIFT SHALL abort the word with no word_done pulse; the remaining bits are discarded.

Configuration
REQ-025 Macro SER_LEN_EN defined: the in_len port exists, L=in_len, and in_len of 0 or greater than W SHALL be treated as W.
REQ-026 Macro SER_LEN_EN undefined: no in_len port, and L=W for every word.

Structure
REQ-027 Package msb_serializer_pkg SHALL hold the state enum (IDLE, SHIFT) and the default-width constant SER_W_DEFAULT=8.
REQ-028 No sub-module is required; shift register, counter and FSM SHALL sit in msb_serializer.
REQ-029 For system tests, the top level instantiates msb_serializer driving the existing divisible-by-3 checker via ser_din/ser_rstn.

Verification
REQ-030 W=8, accept 8'h06 at edge N -> ser_din 0,0,0,0,0,1,1,0 in cycles N+1..N+8; word_done in N+9; checker dout=1 in N+9.
REQ-031 W=8, accept 8'h07 -> word_done in N+9 with checker dout=0; ser_rstn=0 in N+9 and checker cleared at the N+10 edge.
REQ-032 Two words (8'h03, 8'hFF) with in_valid held high -> second accept at the edge ending N+9; bits in N+10..N+17; word_done in N+9 and N+18; dout 1 then 1.
REQ-033 resetn=0 for one cycle during the 4th bit of 8'hAA -> no word_done; IDLE outputs next cycle; the next word 8'h09 serializes correctly with dout=1.
REQ-034 With SER_LEN_EN: in_len=3, in_data=8'h05 -> bits 1,0,1 in N+1..N+3 and word_done in N+4. in_len=0 -> behaves as L=8.
REQ-035 in_valid held low for 20 cycles -> ser_rstn stays 0, word_done stays 0, in_ready stays 1 throughout.
